tcm_preloader: RTL

Boot-time image loader that sits directly upstream of riftCore's ITCM and the DTCM A/B banks. It replaces hierarchical testbench preloading with a real write port. It takes a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit ITCM words and 64-bit DTCM words, and writes them in order. It holds the core in reset until the whole image has landed.

---
 rtl/tcm_preload_pkg.sv | 23 ++
 rtl/tcm_byte_packer.sv | 41 ++++
 rtl/tcm_preloader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tcm_preload_pkg.sv
// tcm_preload_pkg: FSM state codes, lane counts and default image geometry shared by the TCM preloader
package tcm_preload_pkg;

    localparam int ITCM_LANES     = 4;
    localparam int DTCM_LANES     = 8;
    localparam int DTCM_GROUP     = 16;

    localparam int ITCM_AW_DEF    = 12;
    localparam int DTCM_AW_DEF    = 10;
    localparam int ITCM_WORDS_DEF = 4096;
    localparam int DTCM_PAIRS_DEF = 1000;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD_I = 3'd1;
    localparam state_t S_LOAD_D = 3'd2;
    localparam state_t S_FIN    = 3'd3;
    localparam state_t S_DONE   = 3'd4;
    localparam state_t S_CSUM   = 3'd5;
    localparam state_t S_ERR    = 3'd6;

endpackage

// File: rtl/tcm_byte_packer.sv
// tcm_byte_packer: little-endian byte shift-register packer producing ITCM_LANES- or LANES-byte words
module tcm_byte_packer import tcm_preload_pkg::*; #(
    parameter int LANES = DTCM_LANES
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clr,
    input  logic               wide,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               full,
    output logic [8*LANES-1:0] word
);

    localparam int W = 8 * LANES;

    logic [W-1:0] sr;
    logic [W-1:0] nxt;
    logic [3:0]   cnt;
    logic [3:0]   last;

    // New bytes enter at the top so the first byte ends up in the lowest lane once the word is complete
    always_comb begin
        nxt  = {in_data, sr[W-1:8]};
        last = wide ? 4'(LANES - 1) : 4'(ITCM_LANES - 1);
        full = in_valid && cnt == last;
        word = wide ? nxt : nxt >> (W - 8 * ITCM_LANES);
    end

    // Shift in accepted bytes and restart the lane count whenever a word completes or a load restarts
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            sr  <= nxt;
            cnt <= full ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/tcm_preloader.sv
// tcm_preloader: streams a boot image into ITCM and DTCM A/B banks, holding the core in reset until done;
// define TCM_PRELOAD_CHECKSUM_EN to require a trailing 32-bit byte-sum checksum after the image
module tcm_preloader import tcm_preload_pkg::*; #(
    parameter int ITCM_AW    = ITCM_AW_DEF,
    parameter int DTCM_AW    = DTCM_AW_DEF,
    parameter int ITCM_WORDS = ITCM_WORDS_DEF,
    parameter int DTCM_PAIRS = DTCM_PAIRS_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               s_valid,
    input  logic [7:0]         s_data,
    output logic               s_ready,
    output logic               itcm_we,
    output logic [ITCM_AW-1:0] itcm_addr,
    output logic [31:0]        itcm_wdata,
    output logic               dtcm_a_we,
    output logic               dtcm_b_we,
    output logic [DTCM_AW-1:0] dtcm_addr,
    output logic [63:0]        dtcm_wdata,
    output logic               core_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [ITCM_AW:0] I_LAST = (ITCM_AW + 1)'(ITCM_WORDS - 1);
    localparam logic [DTCM_AW:0] D_LAST = (DTCM_AW + 1)'(DTCM_PAIRS - 1);
`ifdef TCM_PRELOAD_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FIN;
`endif

    state_t           state;
    logic [ITCM_AW:0] icnt;
    logic [DTCM_AW:0] pcnt;
    logic             half;
    logic             accept;
    logic             launch;
    logic             full;
    logic [63:0]      word;

    // Status and handshake depend only on the registered state, never on s_valid
    always_comb begin
        s_ready  = state == S_LOAD_I || state == S_LOAD_D || state == S_CSUM;
        busy     = s_ready || state == S_FIN;
        done     = state == S_DONE;
        core_rst = !done;
        accept   = s_valid && s_ready;
        launch   = start && !busy;
    end

    tcm_byte_packer #(.LANES(DTCM_LANES)) packer (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (launch),
        .wide     (state == S_LOAD_D),
        .in_valid (accept),
        .in_data  (s_data),
        .full     (full),
        .word     (word)
    );

`ifdef TCM_PRELOAD_CHECKSUM_EN
    logic [31:0] sum;

    // Running byte sum of the image proper; the trailing checksum bytes are not added
    always_ff @(posedge CLK) begin
        if (RST || launch) sum <= '0;
        else if (accept && state != S_CSUM) sum <= sum + 32'(s_data);
    end

    assign err = state == S_ERR;
`else
    assign err = 1'b0;
`endif

    // Phase sequencing and one-cycle write strobes; the completing write also moves the FSM on
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            icnt       <= '0;
            pcnt       <= '0;
            half       <= 1'b0;
            itcm_we    <= 1'b0;
            itcm_addr  <= '0;
            itcm_wdata <= '0;
            dtcm_a_we  <= 1'b0;
            dtcm_b_we  <= 1'b0;
            dtcm_addr  <= '0;
            dtcm_wdata <= '0;
        end else begin
            itcm_we   <= 1'b0;
            dtcm_a_we <= 1'b0;
            dtcm_b_we <= 1'b0;
            if (launch) begin
                state <= S_LOAD_I;
                icnt  <= '0;
                pcnt  <= '0;
                half  <= 1'b0;
            end else if (state == S_FIN) begin
                state <= S_DONE;
            end else if (full && state == S_LOAD_I) begin
                itcm_we    <= 1'b1;
                itcm_addr  <= icnt[ITCM_AW-1:0];
                itcm_wdata <= word[31:0];
                icnt       <= icnt + (ITCM_AW + 1)'(1);
                if (icnt == I_LAST) state <= (DTCM_PAIRS == 0) ? S_TAIL : S_LOAD_D;
            end else if (full && state == S_LOAD_D) begin
                dtcm_addr  <= pcnt[DTCM_AW-1:0];
                dtcm_wdata <= word;
                dtcm_a_we  <= !half;
                dtcm_b_we  <= half;
                half       <= !half;
                if (half) begin
                    pcnt <= pcnt + (DTCM_AW + 1)'(1);
                    if (pcnt == D_LAST) state <= S_TAIL;
                end
            end
`ifdef TCM_PRELOAD_CHECKSUM_EN
            else if (full && state == S_CSUM) begin
                state <= (word[31:0] == sum) ? S_FIN : S_ERR;
            end
`endif
        end
    end

endmodule
